// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/WB sequencer for the RV32 core: owns pc and the instruction register.
// Optional performance counters are enabled with `define SEQ_PERF_EN.
module core_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        rst,
   output logic        ifu_req,
   output logic [31:0] ifu_addr,
   input  logic        ifu_rvalid,
   input  logic [31:0] ifu_rdata,
   output logic [31:0] inst,
   input  logic        load,
   input  logic        store,
   input  logic        en_Wreg,
   input  logic [31:0] next_pc,
   output logic        lsu_req,
   output logic        lsu_we,
   input  logic        lsu_done,
   output logic        reg_wen,
   output logic [31:0] pc,
   output logic        halted,
   output logic        error,
   output logic [31:0] perf_cycle,
   output logic [31:0] perf_retire
);

   localparam logic [31:0] EBREAK      = 32'h0010_0073;
   localparam logic [31:0] NOP         = 32'h0000_0013;
   localparam logic [7:0]  TIMEOUT_CNT = 8'(TIMEOUT);

   typedef enum logic [2:0] {
      S_FETCH = 3'd0,
      S_EXEC  = 3'd1,
      S_MEM   = 3'd2,
      S_WB    = 3'd3,
      S_HALT  = 3'd4,
      S_ERR   = 3'd5
   } state_t;

   state_t     state, state_nxt;
   logic [7:0] wait_cnt, wait_cnt_nxt;
   logic       misaligned;

   assign misaligned = |next_pc[1:0];

   // Handshake: a request stays high for the whole FETCH/MEM state; a response
   // (ifu_rvalid / lsu_done) is accepted only on a rising edge while in that state.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      case (state)
         S_FETCH: begin
            if (ifu_rvalid) begin
               state_nxt    = S_EXEC;
               wait_cnt_nxt = 8'd0;
            end else if (wait_cnt == TIMEOUT_CNT) begin
               state_nxt = S_ERR;
            end else begin
               wait_cnt_nxt = wait_cnt + 8'd1;
            end
         end
         S_EXEC: begin
            if (inst == EBREAK)     state_nxt = S_HALT;
            else if (load || store) state_nxt = S_MEM;
            else                    state_nxt = S_WB;
         end
         S_MEM: begin
            if (lsu_done) begin
               state_nxt    = S_WB;
               wait_cnt_nxt = 8'd0;
            end else if (wait_cnt == TIMEOUT_CNT) begin
               state_nxt = S_ERR;
            end else begin
               wait_cnt_nxt = wait_cnt + 8'd1;
            end
         end
         S_WB:    state_nxt = misaligned ? S_ERR : S_FETCH;
         default: state_nxt = state;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_FETCH;
         wait_cnt <= 8'd0;
         pc       <= RESET_PC;
         inst     <= NOP;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (state == S_FETCH && ifu_rvalid) inst <= ifu_rdata;
         if (state == S_WB && !misaligned)   pc   <= next_pc;
      end
   end

   // HALT and ERR are terminal, so the status flags are sticky by construction.
   assign ifu_req  = (state == S_FETCH);
   assign ifu_addr = pc;
   assign lsu_req  = (state == S_MEM);
   assign lsu_we   = (state == S_MEM) && store;
   assign reg_wen  = (state == S_WB) && en_Wreg && !store;
   assign halted   = (state == S_HALT);
   assign error    = (state == S_ERR);

`ifdef SEQ_PERF_EN
   logic [31:0] cycle_q, retire_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_q  <= 32'd0;
         retire_q <= 32'd0;
      end else begin
         if (state != S_HALT && state != S_ERR) cycle_q  <= cycle_q + 32'd1;
         if (state == S_WB && !misaligned)      retire_q <= retire_q + 32'd1;
      end
   end

   assign perf_cycle  = cycle_q;
   assign perf_retire = retire_q;
`else
   assign perf_cycle  = 32'd0;
   assign perf_retire = 32'd0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: directed instruction flows with a pc scoreboard,
// plus a second instance with TIMEOUT=4 for the fetch timeout path.
module tb_core_sequencer;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;
   localparam logic [31:0] EBREAK   = 32'h0010_0073;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst_to = 1'b1;
   always #5 clk = ~clk;

   logic        ifu_rvalid = 1'b0;
   logic [31:0] ifu_rdata  = 32'd0;
   logic        load = 1'b0, store = 1'b0, en_wreg = 1'b0, lsu_done = 1'b0;
   logic [31:0] next_pc = 32'd0;
   logic        ifu_req, lsu_req, lsu_we, reg_wen, halted, error;
   logic [31:0] ifu_addr, inst, pc, perf_cycle, perf_retire;

   logic        tie0 = 1'b0;
   logic [31:0] tie0_32 = 32'd0;
   logic        to_ifu_req, to_lsu_req, to_lsu_we, to_reg_wen, to_halted, to_error;
   logic [31:0] to_ifu_addr, to_inst, to_pc, to_perf_cycle, to_perf_retire;

   core_sequencer #(.RESET_PC(RESET_PC), .TIMEOUT(255)) dut (
      .clk(clk), .rst(rst),
      .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
      .inst(inst), .load(load), .store(store), .en_Wreg(en_wreg), .next_pc(next_pc),
      .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_done(lsu_done), .reg_wen(reg_wen),
      .pc(pc), .halted(halted), .error(error),
      .perf_cycle(perf_cycle), .perf_retire(perf_retire)
   );

   core_sequencer #(.RESET_PC(RESET_PC), .TIMEOUT(4)) dut_to (
      .clk(clk), .rst(rst_to),
      .ifu_req(to_ifu_req), .ifu_addr(to_ifu_addr), .ifu_rvalid(tie0), .ifu_rdata(tie0_32),
      .inst(to_inst), .load(tie0), .store(tie0), .en_Wreg(tie0), .next_pc(tie0_32),
      .lsu_req(to_lsu_req), .lsu_we(to_lsu_we), .lsu_done(tie0), .reg_wen(to_reg_wen),
      .pc(to_pc), .halted(to_halted), .error(to_error),
      .perf_cycle(to_perf_cycle), .perf_retire(to_perf_retire)
   );

   // scoreboard
   logic [31:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_pc = RESET_PC;
   logic [31:0] exp_pc = RESET_PC;
   int          exp_retire = 0;
   int          exp_wen = 0;
   int          wen_seen = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_perf();
`ifdef SEQ_PERF_EN
      check_val("perf_retire", perf_retire, exp_retire);
`else
      check_val("perf_retire_off", perf_retire, 32'd0);
`endif
   endtask

   // Every pc change must match the next retired target in the queue.
   task automatic pc_monitor();
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (reg_wen) wen_seen++;
            if (pc !== last_pc) begin
               if (exp_q.size() == 0) check_val("pc_unexpected", pc, last_pc);
               else                   check_val("pc_seq", pc, exp_q.pop_front());
               last_pc = pc;
            end
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      last_pc    = RESET_PC;
      exp_pc     = RESET_PC;
      exp_retire = 0;
      ifu_rvalid = 1'b0; load = 1'b0; store = 1'b0; en_wreg = 1'b0; lsu_done = 1'b0;
      @(negedge clk);
      check_val("rst_pc", pc, RESET_PC);
      check_val("rst_inst", inst, 32'h0000_0013);
      check_val("rst_flags", {ifu_req, lsu_req, reg_wen, halted, error}, 32'b10000);
      check_val("rst_perf_cycle", perf_cycle, 32'd0);
      check_perf();
      rst = 1'b0;
   endtask

   // Called at a negedge in the first FETCH cycle; returns at the negedge of the next FETCH.
   task automatic run_instr(input logic [31:0] ins, input logic ld, input logic st,
                            input logic wen, input int fwait, input int mwait,
                            input logic [31:0] npc);
      int   cyc;
      logic is_mem;
      logic bad;
      cyc    = 0;
      is_mem = ld | st;
      bad    = |npc[1:0];
      check_val("fetch_req", ifu_req, 32'd1);
      check_val("fetch_addr", ifu_addr, exp_pc);
      repeat (fwait) begin
         ifu_rdata = $urandom;
         @(negedge clk); cyc++;
         check_val("fetch_hold", {31'd0, ifu_req}, 32'd1);
         check_val("fetch_addr_stable", ifu_addr, exp_pc);
      end
      ifu_rvalid = 1'b1; ifu_rdata = ins;
      @(negedge clk); cyc++;
      ifu_rvalid = 1'b0; ifu_rdata = $urandom;
      load = ld; store = st; en_wreg = wen; next_pc = npc;
      check_val("exec_inst", inst, ins);
      check_val("exec_outs", {ifu_req, lsu_req, reg_wen}, 32'd0);
      if (ins == EBREAK) begin
         @(negedge clk);
         return;
      end
      if (is_mem) begin
         lsu_done = (mwait > 0);
         @(negedge clk); cyc++;
         lsu_done = 1'b0;
         repeat (mwait) begin
            check_val("mem_req", {lsu_req, lsu_we}, {30'd0, 1'b1, st});
            @(negedge clk); cyc++;
         end
         check_val("mem_req_last", {lsu_req, lsu_we}, {30'd0, 1'b1, st});
         lsu_done = 1'b1;
         @(negedge clk); cyc++;
         lsu_done = 1'b0;
      end else begin
         @(negedge clk); cyc++;
      end
      check_val("wb_wen", reg_wen, {31'd0, wen & ~st});
      check_val("wb_reqs", {ifu_req, lsu_req}, 32'd0);
      if (wen && !st) exp_wen++;
      if (!bad) begin
         exp_q.push_back(npc);
         exp_pc = npc;
         exp_retire++;
      end
      @(negedge clk); cyc++;
      load = 1'b0; store = 1'b0; en_wreg = 1'b0;
      check_val("wb_single", reg_wen, 32'd0);
      if (bad) begin
         check_val("misalign_err", {error, ifu_req}, 32'b10);
         check_val("misalign_pc", pc, exp_pc);
      end else begin
         check_val("next_fetch", ifu_req, 32'd1);
         check_val("latency", cyc, 3 + fwait + (is_mem ? 1 + mwait : 0));
      end
      check_perf();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] frozen;
      fork
         pc_monitor();
      join_none
      do_reset();

      // timeout instance: ERR after exactly 5 FETCH cycles, sticky afterwards
      rst_to = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check_val("to_wait", {to_error, to_ifu_req}, 32'b01);
      end
      @(negedge clk);
      check_val("to_err", {to_error, to_ifu_req, to_lsu_req}, 32'b100);
      repeat (3) @(negedge clk);
      check_val("to_sticky", {to_error, to_pc}, {31'd0, 1'b1, RESET_PC});

      // back-to-back addi; the main DUT has been fetching this whole time
      do_reset();
      for (int i = 0; i < 3; i++)
         run_instr(32'h0010_0093, 1'b0, 1'b0, 1'b1, 0, 0, exp_pc + 32'd4);
      for (int i = 0; i < 3; i++)
         run_instr(32'h0020_8093, 1'b0, 1'b0, 1'b1, $urandom_range(1, 3), 0, exp_pc + 32'd4);
      run_instr(32'h0100_006f, 1'b0, 1'b0, 1'b1, 0, 0, exp_pc + 32'd16);
      run_instr(32'h0000_8463, 1'b0, 1'b0, 1'b0, 1, 0, exp_pc + 32'd8);
      run_instr(32'h0000_a103, 1'b1, 1'b0, 1'b1, 0, 2, exp_pc + 32'd4);
      run_instr(32'h0020_a023, 1'b0, 1'b1, 1'b1, 0, 1, exp_pc + 32'd4);
      run_instr(32'h0000_a183, 1'b1, 1'b0, 1'b1, 2, $urandom_range(0, 3), exp_pc + 32'd4);

      // misaligned target: write-back fires, pc holds, ERR
      run_instr(32'h0020_00e7, 1'b0, 1'b0, 1'b1, 0, 0, exp_pc + 32'd2);
      repeat (2) @(negedge clk);
      check_val("err_sticky", {error, halted, ifu_req}, 32'b100);

      // ebreak: halts with pc unchanged, responses ignored, cycle counter frozen
      do_reset();
      run_instr(32'h0010_0093, 1'b0, 1'b0, 1'b1, 0, 0, exp_pc + 32'd4);
      run_instr(EBREAK, 1'b0, 1'b0, 1'b0, 0, 0, 32'd0);
      check_val("halt_flags", {halted, error, ifu_req, lsu_req, reg_wen}, 32'b10000);
      check_val("halt_pc", pc, exp_pc);
      frozen = perf_cycle;
      ifu_rvalid = 1'b1; ifu_rdata = 32'h0010_0093;
      repeat (3) @(negedge clk);
      ifu_rvalid = 1'b0;
      check_val("halt_sticky", {halted, ifu_req}, 32'b10);
      check_val("halt_inst", inst, EBREAK);
      check_val("halt_perf_cycle", perf_cycle, frozen);
`ifndef SEQ_PERF_EN
      check_val("perf_cycle_off", perf_cycle, 32'd0);
`endif
      check_perf();

      // reset during MEM with a stale lsu_done one cycle later
      do_reset();
      run_instr(32'h0010_0093, 1'b0, 1'b0, 1'b1, 0, 0, exp_pc + 32'd4);
      ifu_rvalid = 1'b1; ifu_rdata = 32'h0000_a103;
      @(negedge clk);
      ifu_rvalid = 1'b0; load = 1'b1; en_wreg = 1'b1; next_pc = exp_pc + 32'd4;
      @(negedge clk);
      check_val("abort_in_mem", lsu_req, 32'd1);
      rst = 1'b1;
      #1;
      last_pc = RESET_PC;
      exp_pc  = RESET_PC;
      exp_retire = 0;
      check_val("abort_async", {pc, ifu_req, lsu_req, reg_wen}, {RESET_PC, 3'b100});
      @(negedge clk);
      rst = 1'b0; lsu_done = 1'b1;
      @(negedge clk);
      lsu_done = 1'b0; load = 1'b0; en_wreg = 1'b0;
      check_val("stale_done", {ifu_req, lsu_req, reg_wen}, 32'b100);
      check_val("stale_pc", pc, RESET_PC);
      check_val("stale_inst", inst, 32'h0000_0013);
      run_instr(32'h0010_0093, 1'b0, 1'b0, 1'b1, 0, 0, exp_pc + 32'd4);

      @(negedge clk);
      check_val("wen_count", wen_seen, exp_wen);
      check_val("queue_empty", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
